serial_word_receiver: RTL and testbench

Serial-in, parallel-out capture stage directly downstream of the team's parallel-load shift register. It samples the LSB-first bit stream that the shift register emits, reassembles the word, and presents it on a registered parallel output with a valid/acknowledge handshake. It also flags overruns and, optionally, checks a parity bit.

---
 rtl/serial_word_receiver.sv | 131 +++++++++++++
 tb/tb_serial_word_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out word capture with valid/ack handshake and sticky overrun flag.
// Define PARITY_RX_EN to append and check one even-parity bit per frame.
module serial_word_receiver #(
  parameter int bitLength = 16
) (
  input  logic                 shiftClk,
  input  logic                 reset,
  input  logic                 startCapture,
  input  logic                 serialIn,
  input  logic                 dataAck,
  output logic [bitLength-1:0] dataOut,
  output logic                 dataValid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 parityError
);

  localparam int CW = $clog2(bitLength);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE
`ifdef PARITY_RX_EN
    , PARITY
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        bit_count;
  logic [bitLength-1:0] buffer;
  logic [bitLength-1:0] word;
  logic                 commit;
  logic                 restart;
  logic                 last_bit;

  assign last_bit = (bit_count == CW'(bitLength - 1));
  assign busy     = (state != IDLE);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    restart   = 1'b0;
    word      = {serialIn, buffer[bitLength-1:1]};
    case (state)
      IDLE: begin
        if (startCapture) begin
          state_nxt = CAPTURE;
          restart   = 1'b1;
        end
      end
      CAPTURE: begin
        if (last_bit) begin
`ifdef PARITY_RX_EN
          state_nxt = PARITY;
`else
          state_nxt = IDLE;
          commit    = 1'b1;
`endif
        end
        // A start here restarts the frame; on the commit edge the word still commits.
        if (startCapture) begin
          state_nxt = CAPTURE;
          restart   = 1'b1;
        end
      end
`ifdef PARITY_RX_EN
      PARITY: begin
        word      = buffer;
        commit    = 1'b1;
        state_nxt = startCapture ? CAPTURE : IDLE;
        restart   = startCapture;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PARITY_RX_EN
  logic parity_q;
  logic parity_calc;

  // In PARITY the current serial bit is the parity bit; even parity over word plus bit.
  assign parity_calc = (^word) ^ serialIn;
  assign parityError = parity_q;

  always_ff @(posedge shiftClk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (commit && !(dataValid && !dataAck)) begin
      parity_q <= parity_calc;
    end
  end
`else
  assign parityError = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge shiftClk) begin
    if (reset) begin
      state     <= IDLE;
      bit_count <= '0;
      buffer    <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (restart) begin
        bit_count <= '0;
        buffer    <= '0;
      end else if (state == CAPTURE) begin
        bit_count <= bit_count + CW'(1);
        buffer    <= {serialIn, buffer[bitLength-1:1]};
      end

      if (commit) begin
        if (dataValid && !dataAck) begin
          overrun <= 1'b1;
        end else begin
          dataOut   <= word;
          dataValid <= 1'b1;
        end
      end else if (dataValid && dataAck) begin
        dataValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: table-driven frames plus hand-written corner sequences.
module tb_serial_word_receiver;

  localparam int W = 16;

  logic         shiftClk;
  logic         reset;
  logic         startCapture;
  logic         serialIn;
  logic         dataAck;
  logic [W-1:0] dataOut;
  logic         dataValid;
  logic         busy;
  logic         overrun;
  logic         parityError;

  int n_checks = 0;
  int n_passed = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  typedef struct {
    logic [W-1:0] word;
    logic         pbit;
    logic [W-1:0] exp_data;
    logic         exp_perr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  serial_word_receiver #(.bitLength(W)) dut (
    .shiftClk    (shiftClk),
    .reset       (reset),
    .startCapture(startCapture),
    .serialIn    (serialIn),
    .dataAck     (dataAck),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .busy        (busy),
    .overrun     (overrun),
    .parityError (parityError)
  );

  initial shiftClk = 1'b0;
  always #5 shiftClk = ~shiftClk;

  task automatic tick();
    @(posedge shiftClk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_passed++;
    else $display("FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic ack_pulse();
    dataAck = 1'b1;
    tick();
    dataAck = 1'b0;
  endtask

  // Drives one frame. chained: the start edge was already issued by the previous frame's commit edge.
  task automatic run_frame(input logic [W-1:0] word, input logic pbit, input logic exp_perr,
                           input logic ack_commit, input logic chained, input logic chain_next,
                           input logic expect_drop, input logic check_early);
    exp_t e;
    logic saw_valid;
    saw_valid = 1'b0;
    if (!expect_drop) begin
      e.data = word;
`ifdef PARITY_RX_EN
      e.perr = exp_perr;
`else
      e.perr = 1'b0;
`endif
      sb.push_back(e);
    end
    if (!chained) begin
      startCapture = 1'b1;
      serialIn     = 1'b0;
      tick();
    end
    startCapture = 1'b0;
    for (int i = 0; i < W; i++) begin
      serialIn = word[i];
`ifndef PARITY_RX_EN
      if (i == W - 1) begin
        dataAck      = ack_commit;
        startCapture = chain_next;
      end
`endif
      tick();
      if (i < W - 1 && dataValid) saw_valid = 1'b1;
    end
`ifdef PARITY_RX_EN
    if (dataValid) saw_valid = 1'b1;
    serialIn     = pbit;
    dataAck      = ack_commit;
    startCapture = chain_next;
    tick();
`endif
    dataAck      = 1'b0;
    startCapture = 1'b0;
    if (check_early) check("no_early_commit", {31'b0, saw_valid}, 32'd0);
    if (!expect_drop) begin
      e = sb.pop_front();
      check("data_out", {16'b0, dataOut}, {16'b0, e.data});
      check("parity_error", {31'b0, parityError}, {31'b0, e.perr});
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},    {16'b0, dataOut}, 32'd0);
    check({tag, "_valid"},   {31'b0, dataValid}, 32'd0);
    check({tag, "_busy"},    {31'b0, busy}, 32'd0);
    check({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
    check({tag, "_perr"},    {31'b0, parityError}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{word: 16'h0001, pbit: 1'b1, exp_data: 16'h0001, exp_perr: 1'b0};
    vecs[1] = '{word: 16'h0001, pbit: 1'b0, exp_data: 16'h0001, exp_perr: 1'b1};
    vecs[2] = '{word: 16'hFFFF, pbit: 1'b0, exp_data: 16'hFFFF, exp_perr: 1'b0};
    vecs[3] = '{word: 16'h8000, pbit: 1'b1, exp_data: 16'h8000, exp_perr: 1'b0};
    vecs[4] = '{word: 16'h7FFF, pbit: 1'b0, exp_data: 16'h7FFF, exp_perr: 1'b1};
    vecs[5] = '{word: 16'h0000, pbit: 1'b1, exp_data: 16'h0000, exp_perr: 1'b1};

    reset = 1'b1; startCapture = 1'b0; serialIn = 1'b0; dataAck = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_values("reset");

    // Serial input is ignored while idle.
    serialIn = 1'b1;
    tick(); tick();
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_valid", {31'b0, dataValid}, 32'd0);

    // Basic frame with latency check.
    run_frame(16'hA5C3, ^16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_valid", {31'b0, dataValid}, 32'd1);
    check("basic_busy", {31'b0, busy}, 32'd0);

    // Ack clears valid, data is held.
    ack_pulse();
    check("ack_valid", {31'b0, dataValid}, 32'd0);
    check("ack_data_held", {16'b0, dataOut}, 32'h0000A5C3);

    // Back-to-back frames without ack: second word dropped, overrun sticks.
    run_frame(16'h1234, ^16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b2b_busy_restart", {31'b0, busy}, 32'd1);
    run_frame(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("overrun_data_kept", {16'b0, dataOut}, 32'h00001234);
    check("overrun_flag", {31'b0, overrun}, 32'd1);
    check("overrun_valid", {31'b0, dataValid}, 32'd1);
    ack_pulse();
    check("overrun_ack_valid", {31'b0, dataValid}, 32'd0);
    check("overrun_sticky", {31'b0, overrun}, 32'd1);
    tick();
    check("ack_ignored_no_valid", {31'b0, dataValid}, 32'd0);

    reset = 1'b1; tick(); reset = 1'b0;
    check("overrun_cleared", {31'b0, overrun}, 32'd0);

    // Commit and ack on the same edge: new word loads, no overrun.
    run_frame(16'h1111, ^16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(16'h2222, ^16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("simul_valid", {31'b0, dataValid}, 32'd1);
    check("simul_overrun", {31'b0, overrun}, 32'd0);

    // Table of frames, each acked on its commit edge.
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].exp_data, vecs[v].pbit, vecs[v].exp_perr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_valid", v), {31'b0, dataValid}, 32'd1);
      check($sformatf("vec%0d_overrun", v), {31'b0, overrun}, 32'd0);
    end

    // Restart after 7 bits; only the second frame commits.
    ack_pulse();
    startCapture = 1'b1; tick(); startCapture = 1'b0;
    for (int i = 0; i < 7; i++) begin
      serialIn = 1'($urandom_range(0, 1));
      tick();
    end
    run_frame(16'h00FF, ^16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_valid", {31'b0, dataValid}, 32'd1);

    // Reset at bit 9 with a valid word and overrun pending.
    run_frame(16'hBEEF, ^16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_reset_overrun", {31'b0, overrun}, 32'd1);
    startCapture = 1'b1; tick(); startCapture = 1'b0;
    for (int i = 0; i < 9; i++) begin
      serialIn = 1'b1;
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_values("midreset");
    run_frame(16'h3C3C, ^16'h3C3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_reset_valid", {31'b0, dataValid}, 32'd1);

    check("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
